countdown_timer: RTL and testbench

Loadable down-counter with a valid/ready load handshake, an abort input and a one-cycle `done` pulse at terminal count. It is the complement of the free-running up-counter with a combinational terminal-count flag used in the simulator regression benches. It loads a start value, counts down to zero and signals completion. It serves as a delay or timeout primitive for testbenches and small designs, and it exercises `posedge` always blocks, asynchronous reset, parameter widths and `ifdef` handling in the simulator.

---
 rtl/countdown_timer_if.sv | 23 ++
 rtl/countdown_timer.sv | 94 +++++++++
 tb/tb_countdown_timer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Load/count handshake bundle for countdown_timer.
// The timer sits on the slave side; the stimulus or owning logic is the master.
interface countdown_timer_if #(
  parameter int WIDTH = 3
);
  logic             load_valid;
  logic [WIDTH-1:0] load_value;
  logic             load_ready;
  logic             abort;
  logic [WIDTH-1:0] cnt;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_value, abort,
    input  load_ready, cnt, busy, done
  );

  modport slave (
    input  load_valid, load_value, abort,
    output load_ready, cnt, busy, done
  );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with valid/ready load, abort and a
// registered one-cycle done pulse when the count expires at zero.
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN (periodic auto-reload;
// loads are also accepted while running and update the reload value).
module countdown_timer #(
  parameter int WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  countdown_timer_if.slave       tmr
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state_q,  state_d;
  logic [WIDTH-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q,   done_d;
  logic             load_ready;
  logic             accept;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  assign load_ready = 1'b1;
`else
  assign load_ready = (state_q == S_IDLE);
`endif

  assign accept = tmr.load_valid & load_ready;

  // Next-state logic: in RUN, abort beats expiry, expiry beats decrement.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (state_q == S_IDLE) begin
      // abort has no effect while idle; cnt simply holds
      if (accept) begin
        cnt_d    = tmr.load_value;
        reload_d = tmr.load_value;
        state_d  = S_RUN;
      end
    end else begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      // a load while running only retargets the next period
      if (accept) begin
        reload_d = tmr.load_value;
      end
      if (tmr.abort) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else if (cnt_q == '0) begin
        done_d = 1'b1;
        // a load landing on the expiry edge goes straight into the count
        cnt_d  = accept ? tmr.load_value : reload_q;
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
`else
      if (tmr.abort) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else if (cnt_q == '0) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
`endif
    end
  end

  // State registers with asynchronous reset back to idle and zero count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign tmr.load_ready = load_ready;
  assign tmr.cnt        = cnt_q;
  assign tmr.busy       = (state_q == S_RUN);
  assign tmr.done       = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer (WIDTH=3). Expected observations are
// queued as each cycle's stimulus is driven and popped after the edge.
// Build with COUNTDOWN_AUTO_RELOAD_EN defined to run the auto-reload sequence.
module tb_countdown_timer;

  typedef struct packed {
    logic [2:0] cnt;
    logic       busy;
    logic       done;
    logic       ready;
  } obs_t;

  logic clk;
  logic rst;

  countdown_timer_if #(.WIDTH(3)) tif ();

  countdown_timer #(.WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .tmr (tif)
  );

  obs_t  exp_q[$];
  string tag_q[$];
  int    vectors;
  int    miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input int c, input bit b, input bit d, input bit r);
    obs_t o;
    o.cnt   = 3'(c);
    o.busy  = b;
    o.done  = d;
    o.ready = r;
    return o;
  endfunction

  task automatic expect_push(input string tag, input obs_t o);
    exp_q.push_back(o);
    tag_q.push_back(tag);
  endtask

  task automatic check_pop();
    obs_t  got;
    obs_t  want;
    string tag;
    got.cnt   = tif.cnt;
    got.busy  = tif.busy;
    got.done  = tif.done;
    got.ready = tif.load_ready;
    want = exp_q.pop_front();
    tag  = tag_q.pop_front();
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed cnt=%0d busy=%b done=%b ready=%b expected cnt=%0d busy=%b done=%b ready=%b",
             tag, got.cnt, got.busy, got.done, got.ready,
             want.cnt, want.busy, want.done, want.ready);
    end
    $display("vec %0d %s cnt=%0d busy=%b done=%b ready=%b", vectors, tag,
             got.cnt, got.busy, got.done, got.ready);
  endtask

  // Drive one cycle of stimulus, queue what must be seen after the edge.
  task automatic step(input string tag, input bit v, input int val, input bit ab,
                      input int c, input bit b, input bit d, input bit r);
    tif.load_valid = v;
    tif.load_value = 3'(val);
    tif.abort      = ab;
    expect_push(tag, mk(c, b, d, r));
    @(posedge clk);
    #1;
    check_pop();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    tif.load_valid = 1'b0;
    tif.load_value = 3'd0;
    tif.abort      = 1'b0;
    rst = 1'b1;
    #1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    expect_push("reset", mk(0, 0, 0, 1));
    check_pop();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // load 2: done every 3 edges
    step("ar_load2", 1, 2, 0, 2, 1, 0, 1);
    step("ar_c1",    0, 0, 0, 1, 1, 0, 1);
    step("ar_c0",    0, 0, 0, 0, 1, 0, 1);
    step("ar_exp1",  0, 0, 0, 2, 1, 1, 1);
    step("ar_c1b",   0, 0, 0, 1, 1, 0, 1);
    step("ar_c0b",   0, 0, 0, 0, 1, 0, 1);
    step("ar_exp2",  0, 0, 0, 2, 1, 1, 1);
    step("ar_c1c",   0, 0, 0, 1, 1, 0, 1);
    // load 5 while cnt=1: count continues, next expiry reloads 5
    step("ar_load5", 1, 5, 0, 0, 1, 0, 1);
    step("ar_exp3",  0, 0, 0, 5, 1, 1, 1);
    for (int i = 4; i >= 0; i--) step("ar_run5", 0, 0, 0, i, 1, 0, 1);
    step("ar_exp4",  0, 0, 0, 5, 1, 1, 1);
    step("ar_abort", 0, 0, 1, 0, 0, 0, 1);
    step("ar_idle",  0, 0, 0, 0, 0, 0, 1);
`else
    expect_push("reset", mk(0, 0, 0, 1));
    check_pop();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // load 3: cnt 3,2,1,0 then done, then done clears
    step("l3_load",  1, 3, 0, 3, 1, 0, 0);
    step("l3_c2",    0, 0, 0, 2, 1, 0, 0);
    step("l3_c1",    0, 0, 0, 1, 1, 0, 0);
    step("l3_c0",    0, 0, 0, 0, 1, 0, 0);
    step("l3_done",  0, 0, 0, 0, 0, 1, 1);
    step("l3_clr",   0, 0, 0, 0, 0, 0, 1);
    // load 0, then load 7 (max value) in the done cycle
    step("l0_load",  1, 0, 0, 0, 1, 0, 0);
    step("l0_done",  0, 0, 0, 0, 0, 1, 1);
    step("l7_b2b",   1, 7, 0, 7, 1, 0, 0);
    for (int i = 6; i >= 0; i--) step("l7_run", 0, 0, 0, i, 1, 0, 0);
    step("l7_done",  0, 0, 0, 0, 0, 1, 1);
    step("l7_clr",   0, 0, 0, 0, 0, 0, 1);
    // load 5, abort at cnt=2: no done
    step("ab_load",  1, 5, 0, 5, 1, 0, 0);
    step("ab_c4",    0, 0, 0, 4, 1, 0, 0);
    step("ab_c3",    0, 0, 0, 3, 1, 0, 0);
    step("ab_c2",    0, 0, 0, 2, 1, 0, 0);
    step("ab_abort", 0, 0, 1, 0, 0, 0, 1);
    step("ab_idle",  0, 0, 0, 0, 0, 0, 1);
    step("ab_idle2", 0, 0, 1, 0, 0, 0, 1);
    // load 4, then a refused load of 1 while busy
    step("rf_load",  1, 4, 0, 4, 1, 0, 0);
    step("rf_c3",    1, 1, 0, 3, 1, 0, 0);
    step("rf_c2",    1, 1, 0, 2, 1, 0, 0);
    step("rf_c1",    1, 1, 0, 1, 1, 0, 0);
    step("rf_c0",    1, 1, 0, 0, 1, 0, 0);
    step("rf_done",  1, 1, 0, 0, 0, 1, 1);
    tif.load_valid = 1'b0;
    step("rf_clr",   0, 0, 0, 0, 0, 0, 1);
    // load 6, async reset between edges at cnt=4
    step("rs_load",  1, 6, 0, 6, 1, 0, 0);
    step("rs_c5",    0, 0, 0, 5, 1, 0, 0);
    step("rs_c4",    0, 0, 0, 4, 1, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    expect_push("rs_async", mk(0, 0, 0, 1));
    check_pop();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step("rs_after", 0, 0, 0, 0, 0, 0, 1);
`endif
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: observed %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
